// File: rtl/sram_audio_ctrl.sv
// -----------------------------------------------------------------------------
// sram_audio_ctrl
//
// Record/playback sequencer sitting in front of the SRAM interface block.
// Record mode: each ADC sample is latched and written to the next SRAM word
// with a two-cycle write strobe. Play mode: each DAC request fetches the next
// word with a two-cycle read strobe and presents it on dac_data. The recorded
// length is tracked so playback stops after the last recorded word.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   btn_record  pulse: start a new recording at address 0
//   btn_play    pulse: start playback at address 0 (ignored when len == 0)
//   btn_stop    pulse: leave the current mode (deferred until an access ends)
//   adc_data    16-bit ADC sample, qualified by adc_valid
//   adc_valid   one-cycle sample strobe
//   dac_req     one-cycle request for the next playback sample
//   dac_data    last fetched sample, held until the next fetch
//   dac_valid   one-cycle strobe marking a dac_data update
//   addr        18-bit SRAM word address
//   read/write  SRAM access strobes, never high together
//   record/play mode lines, high for the whole mode
//   data        shared 16-bit SRAM bus, driven only while record is high
//   len         number of recorded words, 0..262144
//   overrun     sticky: a sample arrived while a write was still running
// -----------------------------------------------------------------------------
module sram_audio_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_record,
  input  logic        btn_play,
  input  logic        btn_stop,
  input  logic [15:0] adc_data,
  input  logic        adc_valid,
  input  logic        dac_req,
  output logic [15:0] dac_data,
  output logic        dac_valid,
  output logic [17:0] addr,
  output logic        read,
  output logic        write,
  output logic        record,
  output logic        play,
  inout  logic [15:0] data,
  output logic [18:0] len,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REC_WAIT  = 3'd1,
    REC_WR1   = 3'd2,
    REC_WR2   = 3'd3,
    PLAY_WAIT = 3'd4,
    PLAY_RD1  = 3'd5,
    PLAY_RD2  = 3'd6
  } state_e;

  localparam logic [17:0] ADDR_LAST = 18'h3FFFF;

  state_e      state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [18:0] len_q, len_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] dac_data_q, dac_data_d;
  logic        dac_valid_q, dac_valid_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        record_q, record_d;
  logic        play_q, play_d;
  logic        overrun_q, overrun_d;
  logic        stop_pend_q, stop_pend_d;

  // Address after the current access; saturates so a full memory never wraps.
  logic [17:0] addr_inc_s;
  logic [18:0] addr_plus1_s;
  logic        stop_seen_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_data_d   = wr_data_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    overrun_d   = overrun_q;
    stop_pend_d = stop_pend_q;

    addr_plus1_s = {1'b0, addr_q} + 19'd1;
    if (addr_q == ADDR_LAST) begin
      addr_inc_s = addr_q;
    end else begin
      addr_inc_s = addr_q + 18'd1;
    end
    // A stop seen during an access is honoured once that access finishes.
    stop_seen_s = stop_pend_q | btn_stop;

    case (state_q)
      IDLE: begin
        if (btn_stop) begin
          state_d = IDLE;
        end else if (btn_record) begin
          state_d   = REC_WAIT;
          addr_d    = 18'd0;
          len_d     = 19'd0;
          overrun_d = 1'b0;
        end else if (btn_play && (len_q != 19'd0)) begin
          state_d = PLAY_WAIT;
          addr_d  = 18'd0;
        end else begin
          state_d = IDLE;
        end
      end

      REC_WAIT: begin
        if (btn_stop) begin
          state_d = IDLE;
        end else if (adc_valid) begin
          state_d   = REC_WR1;
          wr_data_d = adc_data;
        end else begin
          state_d = REC_WAIT;
        end
      end

      REC_WR1: begin
        state_d = REC_WR2;
        if (btn_stop) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        if (adc_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end

      REC_WR2: begin
        len_d  = addr_plus1_s;
        addr_d = addr_inc_s;
        if (adc_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        // The write to the last word fills the memory and ends recording.
        if (stop_seen_s || (addr_q == ADDR_LAST)) begin
          state_d = IDLE;
        end else begin
          state_d = REC_WAIT;
        end
      end

      PLAY_WAIT: begin
        if (btn_stop) begin
          state_d = IDLE;
        end else if (dac_req) begin
          state_d = PLAY_RD1;
        end else begin
          state_d = PLAY_WAIT;
        end
      end

      PLAY_RD1: begin
        state_d = PLAY_RD2;
        if (btn_stop) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
      end

      PLAY_RD2: begin
        dac_data_d  = data;
        dac_valid_d = 1'b1;
        addr_d      = addr_inc_s;
        // Last recorded word fetched: leave play mode with this dac_valid.
        if (stop_seen_s || (addr_plus1_s == len_q)) begin
          state_d = IDLE;
        end else begin
          state_d = PLAY_WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pending stop only lives for the duration of one access.
    if ((state_d == REC_WR1) || (state_d == REC_WR2) ||
        (state_d == PLAY_RD1) || (state_d == PLAY_RD2)) begin
      stop_pend_d = stop_pend_d;
    end else begin
      stop_pend_d = 1'b0;
    end

    // Strobes and mode lines are decoded from the next state so they are
    // registered and change on the same edge as the state.
    write_d  = (state_d == REC_WR1) || (state_d == REC_WR2);
    read_d   = (state_d == PLAY_RD1) || (state_d == PLAY_RD2);
    record_d = (state_d == REC_WAIT) || (state_d == REC_WR1) || (state_d == REC_WR2);
    play_d   = (state_d == PLAY_WAIT) || (state_d == PLAY_RD1) || (state_d == PLAY_RD2);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 18'd0;
      len_q       <= 19'd0;
      wr_data_q   <= 16'd0;
      dac_data_q  <= 16'd0;
      dac_valid_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      record_q    <= 1'b0;
      play_q      <= 1'b0;
      overrun_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_data_q   <= wr_data_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      read_q      <= read_d;
      write_q     <= write_d;
      record_q    <= record_d;
      play_q      <= play_d;
      overrun_q   <= overrun_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // The SRAM interface releases its data side while record is high.
  assign data = record_q ? wr_data_q : 16'hzzzz;

  assign addr      = addr_q;
  assign len       = len_q;
  assign read      = read_q;
  assign write     = write_q;
  assign record    = record_q;
  assign play      = play_q;
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign overrun   = overrun_q;

endmodule
